// File: rtl/dma_if_2d_agen.sv
// 2D address generator for the im2col DMA interface: takes one descriptor and walks the
// zero-padded window row-major, emitting a source-fetch or zero-fill beat per data unit.
module dma_if_2d_agen #(
  parameter int unsigned DU_BYTES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cfg_valid_i,
  output logic        cfg_ready_o,
  input  logic [31:0] input_ptr_i,
  input  logic [31:0] output_ptr_i,
  input  logic [22:0] in_inc_d2_i,
  input  logic [7:0]  n_zeros_top_i,
  input  logic [7:0]  n_zeros_bottom_i,
  input  logic [7:0]  n_zeros_left_i,
  input  logic [7:0]  n_zeros_right_i,
  input  logic [15:0] size_du_d1_i,
  input  logic [15:0] size_du_d2_i,
  output logic        beat_valid_o,
  input  logic        beat_ready_i,
  output logic        beat_pad_o,
  output logic [31:0] beat_src_addr_o,
  output logic [31:0] beat_dst_addr_o,
  output logic        beat_last_o,
  output logic        done_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [31:0] DU_STEP = 32'(DU_BYTES);

  logic [1:0]  state_q;
  logic [22:0] in_inc_q;
  logic [17:0] row_lo_q, row_hi_q, col_lo_q, col_hi_q;
  logic [17:0] last_row_q, last_col_q;
  logic [17:0] r_q, c_q;
  logic [31:0] row_base_q;

  logic [17:0] h_tot, w_tot;
  logic        empty_desc, first_pad;
  logic        beat_fire, row_end, pad_nxt, last_nxt;
  logic [17:0] r_nxt, c_nxt;
  logic [31:0] row_base_nxt, src_nxt;

  assign cfg_ready_o = (state_q == ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

  always_comb begin
    h_tot      = 18'(n_zeros_top_i) + 18'(size_du_d2_i) + 18'(n_zeros_bottom_i);
    w_tot      = 18'(n_zeros_left_i) + 18'(size_du_d1_i) + 18'(n_zeros_right_i);
    empty_desc = (size_du_d1_i == 16'd0) || (size_du_d2_i == 16'd0);
    first_pad  = (n_zeros_top_i != 8'd0) || (n_zeros_left_i != 8'd0);
  end

  // Next-beat position and payload; the row base only advances when leaving a source row.
  always_comb begin
    beat_fire    = (state_q == ST_RUN) && beat_valid_o && beat_ready_i;
    row_end      = (c_q == last_col_q);
    r_nxt        = row_end ? r_q + 18'd1 : r_q;
    c_nxt        = row_end ? 18'd0 : c_q + 18'd1;
    row_base_nxt = (row_end && (r_q >= row_lo_q) && (r_q < row_hi_q))
                   ? row_base_q + {9'd0, in_inc_q} : row_base_q;
    pad_nxt      = (r_nxt < row_lo_q) || (r_nxt >= row_hi_q) ||
                   (c_nxt < col_lo_q) || (c_nxt >= col_hi_q);
    src_nxt      = (c_nxt == col_lo_q) ? row_base_nxt : beat_src_addr_o + DU_STEP;
    last_nxt     = (r_nxt == last_row_q) && (c_nxt == last_col_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      in_inc_q        <= '0;
      row_lo_q        <= '0;
      row_hi_q        <= '0;
      col_lo_q        <= '0;
      col_hi_q        <= '0;
      last_row_q      <= '0;
      last_col_q      <= '0;
      r_q             <= '0;
      c_q             <= '0;
      row_base_q      <= '0;
      beat_valid_o    <= 1'b0;
      beat_pad_o      <= 1'b0;
      beat_last_o     <= 1'b0;
      beat_src_addr_o <= '0;
      beat_dst_addr_o <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid_i) begin
            in_inc_q        <= in_inc_d2_i;
            row_lo_q        <= 18'(n_zeros_top_i);
            row_hi_q        <= 18'(n_zeros_top_i) + 18'(size_du_d2_i);
            col_lo_q        <= 18'(n_zeros_left_i);
            col_hi_q        <= 18'(n_zeros_left_i) + 18'(size_du_d1_i);
            last_row_q      <= h_tot - 18'd1;
            last_col_q      <= w_tot - 18'd1;
            r_q             <= '0;
            c_q             <= '0;
            row_base_q      <= input_ptr_i;
            beat_src_addr_o <= input_ptr_i;
            beat_dst_addr_o <= output_ptr_i;
            if (empty_desc) begin
              state_q <= ST_DONE;
            end else begin
              state_q      <= ST_RUN;
              beat_valid_o <= 1'b1;
              beat_pad_o   <= first_pad;
              beat_last_o  <= (h_tot == 18'd1) && (w_tot == 18'd1);
            end
          end
        end
        ST_RUN: begin
          if (beat_fire) begin
            if (beat_last_o) begin
              state_q      <= ST_DONE;
              beat_valid_o <= 1'b0;
            end else begin
              r_q             <= r_nxt;
              c_q             <= c_nxt;
              row_base_q      <= row_base_nxt;
              beat_pad_o      <= pad_nxt;
              beat_last_o     <= last_nxt;
              beat_dst_addr_o <= beat_dst_addr_o + DU_STEP;
              if (!pad_nxt) begin
                beat_src_addr_o <= src_nxt;
              end
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_if_2d_agen.sv
// Self-checking bench for dma_if_2d_agen: directed test-plan cases plus randomized
// descriptors, compared against a geometric reference model of the padded window.
module tb_dma_if_2d_agen;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_valid_i;
  logic        cfg_ready_o;
  logic [31:0] input_ptr_i, output_ptr_i;
  logic [22:0] in_inc_d2_i;
  logic [7:0]  n_zeros_top_i, n_zeros_bottom_i, n_zeros_left_i, n_zeros_right_i;
  logic [15:0] size_du_d1_i, size_du_d2_i;
  logic        beat_valid_o, beat_ready_i, beat_pad_o, beat_last_o, done_o;
  logic [31:0] beat_src_addr_o, beat_dst_addr_o;

  int check_count = 0;
  int error_count = 0;

  typedef struct {
    logic        pad;
    logic [31:0] src;
    logic [31:0] dst;
    logic        last;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk_i = ~clk_i;

  dma_if_2d_agen #(.DU_BYTES(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .input_ptr_i(input_ptr_i), .output_ptr_i(output_ptr_i), .in_inc_d2_i(in_inc_d2_i),
    .n_zeros_top_i(n_zeros_top_i), .n_zeros_bottom_i(n_zeros_bottom_i),
    .n_zeros_left_i(n_zeros_left_i), .n_zeros_right_i(n_zeros_right_i),
    .size_du_d1_i(size_du_d1_i), .size_du_d2_i(size_du_d2_i),
    .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i), .beat_pad_o(beat_pad_o),
    .beat_src_addr_o(beat_src_addr_o), .beat_dst_addr_o(beat_dst_addr_o),
    .beat_last_o(beat_last_o), .done_o(done_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) else begin
      error_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, ":cfg_ready"}, 32'(cfg_ready_o), 32'd1);
    check_output({tag, ":valid"}, 32'(beat_valid_o), 32'd0);
    check_output({tag, ":pad"}, 32'(beat_pad_o), 32'd0);
    check_output({tag, ":last"}, 32'(beat_last_o), 32'd0);
    check_output({tag, ":src"}, beat_src_addr_o, 32'd0);
    check_output({tag, ":dst"}, beat_dst_addr_o, 32'd0);
    check_output({tag, ":done"}, 32'(done_o), 32'd0);
  endtask

  // Every padded-window position in row-major order, addresses from closed-form arithmetic.
  task automatic build_model(input logic [31:0] in_ptr, input logic [31:0] out_ptr,
                             input logic [22:0] inc, input int t, input int b, input int l,
                             input int rt, input int d1, input int d2);
    int w, h;
    beat_t bt;
    exp_q.delete();
    if (d1 == 0 || d2 == 0) return;
    w = l + d1 + rt;
    h = t + d2 + b;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        bt.pad  = (r < t) || (r >= t + d2) || (c < l) || (c >= l + d1);
        bt.src  = bt.pad ? 32'd0
                         : in_ptr + 32'(r - t) * 32'(inc) + 32'(c - l) * 32'd4;
        bt.dst  = out_ptr + 32'(r * w + c) * 32'd4;
        bt.last = (r == h - 1) && (c == w - 1);
        exp_q.push_back(bt);
      end
    end
  endtask

  // ready_mode: 0 always ready, 1 random, 2 random plus a 5-cycle stall at beat 2.
  task automatic apply_stimulus(input string name, input logic [31:0] in_ptr,
                                input logic [31:0] out_ptr, input logic [22:0] inc,
                                input int t, input int b, input int l, input int rt,
                                input int d1, input int d2, input int ready_mode,
                                input bit hold_valid, input int abort_at);
    int budget, idx, hold_cnt;
    bit stalled;
    logic ready_now;
    beat_t saved, e;
    budget = 0;
    while (!cfg_ready_o && budget < 100) begin
      step();
      budget++;
    end
    check_output({name, ":cfg_ready_idle"}, 32'(cfg_ready_o), 32'd1);
    input_ptr_i      = in_ptr;
    output_ptr_i     = out_ptr;
    in_inc_d2_i      = inc;
    n_zeros_top_i    = 8'(t);
    n_zeros_bottom_i = 8'(b);
    n_zeros_left_i   = 8'(l);
    n_zeros_right_i  = 8'(rt);
    size_du_d1_i     = 16'(d1);
    size_du_d2_i     = 16'(d2);
    cfg_valid_i      = 1'b1;
    build_model(in_ptr, out_ptr, inc, t, b, l, rt, d1, d2);
    step();
    if (hold_valid) begin
      input_ptr_i  = $urandom;
      output_ptr_i = $urandom;
      size_du_d1_i = 16'($urandom_range(1, 9));
    end else begin
      cfg_valid_i = 1'b0;
    end
    if (exp_q.size() == 0) begin
      check_output({name, ":empty_done"}, 32'(done_o), 32'd1);
      check_output({name, ":empty_valid"}, 32'(beat_valid_o), 32'd0);
      cfg_valid_i = 1'b0;
      step();
      check_output({name, ":empty_done_clr"}, 32'(done_o), 32'd0);
      check_output({name, ":empty_ready"}, 32'(cfg_ready_o), 32'd1);
      return;
    end
    check_output({name, ":first_valid"}, 32'(beat_valid_o), 32'd1);
    idx = 0;
    budget = 0;
    hold_cnt = 0;
    stalled = 1'b0;
    while (idx < exp_q.size() && budget < 2000) begin
      if (abort_at > 0 && idx == abort_at) begin
        rst_ni = 1'b0;
        #1;
        check_reset_values({name, ":async_reset"});
        beat_ready_i = 1'b0;
        cfg_valid_i  = 1'b0;
        step();
        rst_ni = 1'b1;
        return;
      end
      if (beat_valid_o) begin
        e = exp_q[idx];
        if (stalled) begin
          check_output({name, ":stall_src"}, beat_src_addr_o, saved.src);
          check_output({name, ":stall_dst"}, beat_dst_addr_o, saved.dst);
          check_output({name, ":stall_pad"}, 32'(beat_pad_o), 32'(saved.pad));
        end
        check_output($sformatf("%s:beat%0d_pad", name, idx), 32'(beat_pad_o), 32'(e.pad));
        check_output($sformatf("%s:beat%0d_dst", name, idx), beat_dst_addr_o, e.dst);
        check_output($sformatf("%s:beat%0d_last", name, idx), 32'(beat_last_o), 32'(e.last));
        if (!e.pad)
          check_output($sformatf("%s:beat%0d_src", name, idx), beat_src_addr_o, e.src);
        check_output({name, ":run_cfg_ready"}, 32'(cfg_ready_o), 32'd0);
        check_output({name, ":run_done"}, 32'(done_o), 32'd0);
        case (ready_mode)
          0: ready_now = 1'b1;
          2: begin
            if (idx == 2 && hold_cnt < 5) begin
              ready_now = 1'b0;
              hold_cnt++;
            end else begin
              ready_now = 1'($urandom_range(0, 1));
            end
          end
          default: ready_now = 1'($urandom_range(0, 1));
        endcase
        beat_ready_i = ready_now;
        if (ready_now) begin
          idx++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          saved.src = beat_src_addr_o;
          saved.dst = beat_dst_addr_o;
          saved.pad = beat_pad_o;
        end
      end else begin
        check_output($sformatf("%s:valid_dropped_beat%0d", name, idx), 32'(beat_valid_o), 32'd1);
        beat_ready_i = 1'b0;
      end
      step();
      budget++;
    end
    check_output({name, ":beat_count"}, 32'(idx), 32'(exp_q.size()));
    beat_ready_i = 1'b0;
    cfg_valid_i  = 1'b0;
    check_output({name, ":done_pulse"}, 32'(done_o), 32'd1);
    check_output({name, ":done_valid"}, 32'(beat_valid_o), 32'd0);
    check_output({name, ":done_cfg_ready"}, 32'(cfg_ready_o), 32'd0);
    step();
    check_output({name, ":done_clr"}, 32'(done_o), 32'd0);
    check_output({name, ":back_idle"}, 32'(cfg_ready_o), 32'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    cfg_valid_i = 1'b0;
    beat_ready_i = 1'b0;
    input_ptr_i = '0;
    output_ptr_i = '0;
    in_inc_d2_i = '0;
    n_zeros_top_i = '0;
    n_zeros_bottom_i = '0;
    n_zeros_left_i = '0;
    n_zeros_right_i = '0;
    size_du_d1_i = '0;
    size_du_d2_i = '0;
    #2;
    check_reset_values("reset");
    step();
    step();
    rst_ni = 1'b1;
    step();

    $display("[TB] plain copy");
    apply_stimulus("plain", 32'h1000, 32'h2000, 23'h10, 0, 0, 0, 0, 3, 2, 0, 1'b0, 0);
    $display("[TB] full padding");
    apply_stimulus("padall", 32'h4000, 32'h8000, 23'h40, 1, 1, 1, 1, 2, 2, 0, 1'b0, 0);
    $display("[TB] backpressure");
    apply_stimulus("stall", 32'h1000, 32'h2000, 23'h10, 0, 0, 0, 0, 3, 2, 2, 1'b0, 0);
    $display("[TB] empty descriptor");
    apply_stimulus("empty", 32'h1000, 32'h2000, 23'h10, 3, 3, 3, 3, 0, 5, 0, 1'b0, 0);
    $display("[TB] address wrap with cfg_valid held");
    apply_stimulus("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 23'h100, 0, 0, 0, 0, 2, 1, 1, 1'b1, 0);
    $display("[TB] reset mid-run");
    apply_stimulus("abort", 32'h3000, 32'h5000, 23'h20, 1, 1, 1, 1, 2, 2, 0, 1'b0, 3);
    apply_stimulus("after_abort", 32'h3000, 32'h5000, 23'h20, 1, 1, 1, 1, 2, 2, 0, 1'b0, 0);

    $display("[TB] randomized descriptors");
    for (int i = 0; i < 8; i++) begin
      apply_stimulus($sformatf("rand%0d", i), $urandom, $urandom, 23'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 5)), int'($urandom_range(1, 4)),
                     1, 1'($urandom_range(0, 1)), 0);
    end

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/dma_if_2d_agen.md
# dma_if_2d_agen

Consumer-side engine for the DMA register interface that the im2col SPC programs. It accepts one transfer descriptor (input/output pointers, 2D sizes in data units, row stride, four zero-padding counts) through a valid/ready handshake. It then walks the padded 2D window row-major, emitting one beat per output data unit: either a source fetch address, or a zero-fill marker. Each beat also carries its destination address. It sits between the SPC's descriptor write port and the DMA read/write channel front-end.

## Interface
- DU_BYTES, 4: bytes per data unit; address step along d1 and along the output.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- cfg_valid_i  in  1  descriptor valid.
- cfg_ready_o  out  1  high when IDLE.
- input_ptr_i  in  32  source base byte address.
- output_ptr_i  in  32  destination base byte address.
- in_inc_d2_i  in  23  source byte stride between consecutive d2 rows (unsigned).
- n_zeros_top_i, n_zeros_bottom_i, n_zeros_left_i, n_zeros_right_i  in  8 each  padding data units.
- size_du_d1_i  in  16  source columns (data units).
- size_du_d2_i  in  16  source rows.
- beat_valid_o  out  1  beat available.
- beat_ready_i  in  1  downstream accepts beat.
- beat_pad_o  out  1  1 = write zero; src address don't-care.
- beat_src_addr_o  out  32  source byte address.
- beat_dst_addr_o  out  32  destination byte address.
- beat_last_o  out  1  final beat of the descriptor.
- done_o  out  1  one-cycle pulse after the final beat is accepted, or on an empty descriptor.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: cfg_ready_o=1. On cfg_valid_i, all descriptor fields are latched into registers. Inputs are don't-care afterwards.
- On accept, with size_du_d1_i==0 or size_du_d2_i==0, the engine goes to DONE with no beats.
- On accept otherwise, the engine goes to RUN.
- Padded geometry:
  - W = left + d1 + right columns; H = top + d2 + bottom rows.
  - Counters are 18-bit, so no overflow is possible.
- RUN: row r in 0..H-1 and column c in 0..W-1, row-major with c fastest.
  - pad = (r<top) | (r>=top+d2) | (c<left) | (c>=left+d1).
  - Non-pad: src = input_ptr + (r-top)*in_inc_d2 + (c-left)*DU_BYTES.
  - Implemented incrementally:
    - Row-base register starts at input_ptr and adds in_inc_d2 after each source row, i.e. rows top..top+d2-1.
    - Column register resets to the row base at c==left and adds DU_BYTES per source column.
  - dst = output_ptr + (r*W+c)*DU_BYTES, implemented as an accumulator adding DU_BYTES per accepted beat.
  - All address arithmetic is modulo 2^32 and wraps silently.
  - beat_last_o = (r==H-1)&(c==W-1).
  - Accepting the last beat moves the engine to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- No new descriptor is accepted outside IDLE. cfg_valid_i in RUN/DONE is ignored and not queued.
- Reset mid-RUN: everything returns to reset values immediately and the descriptor is lost.

## Timing
- Reset values:
  - cfg_ready_o=1
  - beat_valid_o=0, beat_pad_o=0, beat_last_o=0
  - beat_src_addr_o=0, beat_dst_addr_o=0
  - done_o=0
- All beat outputs are registered.
- Descriptor accepted at edge N → first beat valid in cycle N+1.
- Throughput: one beat per cycle while beat_ready_i=1.
- Beat payload is stable while beat_valid_o=1 and beat_ready_i=0. beat_valid_o never drops before acceptance.
- Last beat accepted at edge M → done_o high in cycle M+1 → cfg_ready_o high in cycle M+2.
- Empty descriptor accepted at N → done_o in N+1, no beat_valid_o.
- Total beats = H*W exactly. A descriptor with d1,d2≥1 always yields ≥1 beat.

## Test plan
- Plain copy, no padding.
  - Stimulus: input_ptr=0x1000, output_ptr=0x2000, d1=3, d2=2, in_inc_d2=0x10, pads 0.
  - Response: 6 non-pad beats.
    - src 0x1000,0x1004,0x1008,0x1010,0x1014,0x1018.
    - dst 0x2000..0x2014 step 4.
    - last on beat 6.
    - done_o one cycle later.
- Full padding.
  - Stimulus: d1=2, d2=2, top=bottom=left=right=1.
  - Response: 16 beats.
    - pad pattern row-major 1111/1001/1001/1111.
    - Beat 5 src=input_ptr, beat 6 src=input_ptr+4, beat 9 src=input_ptr+in_inc_d2.
    - dst final = output_ptr+60.
- Backpressure.
  - Stimulus: the plain-copy case above with beat_ready_i toggling randomly, held low 5 cycles at beat 2.
  - Response: payload unchanged while stalled; same 6-beat sequence; no beat dropped or duplicated.
- Empty descriptor.
  - Stimulus: d1=0, d2=5, pads=3.
  - Response: zero beats; done_o in cycle after accept.
- Wrap and ignore.
  - Stimulus: input_ptr=0xFFFF_FFFC, d1=2, d2=1, and cfg_valid_i held high during RUN.
  - Response: src 0xFFFF_FFFC, 0x0000_0000; second descriptor not accepted until IDLE.
- Reset mid-RUN.
  - Stimulus: rst_ni low after 3 of 16 beats.
  - Response: all outputs at reset values asynchronously; new descriptor after reset starts at beat 0.
